// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the narrow store path and the load extend/extract path.
//   - Access size encodings (byte, halfword, word, illegal).
//   - Store sequencer state enum.
//   - Byte-lane count of a data word.
//   - Misalignment predicate for an access size and the low address bits.
package store_narrow_rmw_pkg;

    localparam int BYTE_LANES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // True when an access of the given size is not naturally aligned.
    // The illegal size code is not a misalignment and is rejected separately.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: replaces the byte or halfword selected by the low
// address bits inside an existing memory word with new store data.
//   old_word  in  32  word currently held in memory
//   wdata     in  16  store data (byte stores use bits [7:0])
//   size      in  2   SZ_BYTE / SZ_HALF; any other code passes old_word through
//   addr_lo   in  2   byte offset within the word
//   merged    out 32  old_word with the target lane(s) replaced
// BIG_ENDIAN reverses lane placement: byte lane k lives at bits [8(3-k)+7 -: 8],
// so a halfword at offset 0 occupies bits [31:16] with its high byte at lane 0.
module store_lane_merge
    import store_narrow_rmw_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] old_word,
    input  logic [15:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    logic [1:0] byte_pos;   // physical byte slot inside the word
    logic       half_pos;   // physical halfword slot inside the word

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        byte_pos = BIG_ENDIAN ? ~addr_lo    : addr_lo;     // ~a == 3-a on 2 bits
        half_pos = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
        merged   = old_word;
        case (size)
            SZ_BYTE: merged[{byte_pos, 3'b000} +: 8]   = wdata[7:0];
            SZ_HALF: merged[{half_pos, 4'b0000} +: 16] = wdata[15:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrow store unit: writes a byte, halfword or word from a 32-bit register
// value into a word-only data memory. Sub-word stores run as read-modify-write.
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/ready     store request handshake (ready high only in IDLE)
//   req_addr/size/wdata byte address, size code, register value
//   resp_done           one-cycle pulse: store committed to memory
//   resp_err            one-cycle pulse: request rejected, memory untouched
//   mem_addr            word address (0 when no strobe is active)
//   mem_rd_en/mem_rdata read strobe, data returned one cycle later
//   mem_wr_en/mem_wdata write strobe and full word (0 when no strobe)
// Every output is decoded from the state register and captured registers only,
// so there is no combinational path from req_* to mem_*.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              resp_done,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [1:0]        size_q,   size_d;
    logic [15:0]       data_q,   data_d;     // only the low halfword can reach a lane
    logic [31:0]       merged_q, merged_d;

    logic [31:0]       lane_merged;

    store_lane_merge #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_merge (
        .old_word (mem_rdata),
        .wdata    (data_q),
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .merged   (lane_merged)
    );

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        data_d    = data_q;
        merged_d  = merged_q;

        req_ready = 1'b0;
        resp_done = 1'b0;
        resp_err  = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d = req_addr;
                    size_d = req_size;
                    data_d = req_wdata[15:0];
                    if (req_size == SZ_ILL || is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (req_size == SZ_WORD) begin
                        // A full word needs no old data: skip the read.
                        merged_d = req_wdata;
                        state_d  = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_q[ADDR_W-1:2];
                state_d   = ST_MERGE;
            end
            ST_MERGE: begin
                // mem_rdata answers the READ strobe of the previous cycle.
                merged_d = lane_merged;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = addr_q[ADDR_W-1:2];
                mem_wdata = merged_q;
                resp_done = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                resp_err = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the captured request registers are a handful of flops, so they are
    // reset along with the state; a reset mid-sequence leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            data_q   <= '0;
            merged_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            data_q   <= data_d;
            merged_q <= merged_d;
        end
    end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-side counterpart of the load-path extend unit. The extend unit widens narrow immediates and data to 32 bits; this block narrows a 32-bit register value to a byte, halfword or word and writes it into a word-only data memory.
- Memory has no byte enables, so sub-word stores run as a read-modify-write sequence.
- Sits between the CPU store path and data memory. It drives a stall (`req_ready` low) while busy.

Parameters:
- ADDR_W, 32, byte-address width (memory word address is ADDR_W-2 bits).
- BIG_ENDIAN, 0, lane order: 0 = lane k at bits [8k+7:8k]; 1 = lanes reversed.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  store request.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_wdata  in  32  register value; only low 8/16/32 bits are used.
- resp_done  out  1  one-cycle pulse: store committed to memory.
- resp_err  out  1  one-cycle pulse: request rejected, no memory access.
- mem_addr  out  ADDR_W-2  word address.
- mem_rd_en  out  1  read strobe; data appears on mem_rdata the next cycle.
- mem_rdata  in  32  read data (1-cycle latency).
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  32  full word to write.

Behaviour:
- States: IDLE, READ, MERGE, WRITE, ERR.
- Reset (async, any state): state=IDLE; address, size and data regs = 0.
  - Outputs: req_ready=1, resp_done=0, resp_err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- IDLE:
  - req_ready=1. A handshake is req_valid & req_ready; capture addr, size and wdata on it.
  - Illegal request (size 11, halfword with addr[0]=1, word with addr[1:0]!=0): go to ERR.
  - Legal word: merged_reg=wdata, go to WRITE.
  - Legal byte or halfword: go to READ.
- READ: mem_rd_en=1, mem_addr=addr[ADDR_W-1:2]; go to MERGE.
- MERGE: mem_rdata is valid this cycle. merged_reg = mem_rdata with the target lane(s) replaced; go to WRITE.
  - Byte: lane = addr[1:0], data = wdata[7:0].
  - Halfword: lanes {addr[1],0} and {addr[1],1}, data = wdata[15:0].
  - All other bits come from mem_rdata unchanged.
- WRITE: mem_wr_en=1, mem_addr=word addr, mem_wdata=merged_reg, resp_done=1; go to IDLE.
- ERR: resp_err=1, no memory strobes; go to IDLE.
- Timing and output rules:
  - All outputs are registered or decoded from state only; no combinational path from req_* to mem_*.
  - mem_wdata and mem_addr are 0 when their strobe is low.
- Latency, handshake at cycle 0:
  - Word: write and done at cycle 1.
  - Sub-word: read at cycle 1, merge at cycle 2, write and done at cycle 3.
  - Error: err at cycle 1.
- Back-to-back: a new request is accepted only in IDLE. The first IDLE after WRITE or ERR accepts it, giving a throughput of 1 word store per 2 cycles and 1 sub-word store per 4 cycles.
- Request inputs are ignored outside IDLE. req_wdata upper bits never reach memory for byte and halfword stores.
- Reset mid-sequence: the in-flight store is abandoned and memory is untouched unless the WRITE edge has already occurred. No done or err pulse is produced for the abandoned store.
- resp_done and resp_err are never high together. Exactly one of them pulses per accepted request.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state enum.
  - BYTE_LANES=4.
  - misalignment predicate function. This package is also used by the load extend/extract path.
- Sub-module: store_lane_merge (combinational). Inputs: old word, wdata, size, addr[1:0], BIG_ENDIAN. Output: merged word. Reusable by a future byte-enable memory wrapper.

Test Plan:
- Word store: addr=0x10, size=10, wdata=0xDEADBEEF -> cycle 1 mem_wr_en=1, mem_addr=0x4, mem_wdata=0xDEADBEEF, resp_done=1, no mem_rd_en.
- Byte store: mem[0x4]=0x11223344; addr=0x12, size=00, wdata=0xFFFFFFAB -> read at cycle 1, write 0x11AB3344 and resp_done at cycle 3.
- Halfword store: mem[0x4]=0x11223344; addr=0x12, size=01, wdata=0x0000CAFE -> write 0xCAFE3344. Repeat with addr=0x10 -> write 0x1122CAFE.
- Misaligned and illegal: halfword at 0x13, word at 0x12, size=11 -> resp_err pulse at cycle 1 each, mem_rd_en and mem_wr_en stay 0.
- Back-to-back: req_valid held high with a byte store then a word store -> second handshake in the cycle after the first WRITE, and req_ready low during READ, MERGE and WRITE.
- Reset in MERGE: assert rst during a byte store -> outputs reset immediately, no mem_wr_en, no resp_done, memory unchanged, req_ready=1 after reset.
